// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Holds a per-frame shadow of the BCD digits and drives one digit per slot after a blanking guard.
module seg7_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_en,
    output logic [3:0]              bcd_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    digit_err,
    output logic                    frame_start
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam int unsigned IW = $clog2(NUM_DIGITS);

    typedef enum logic {BLANK, SHOW} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    pending_q, pending_d;
    logic                    first_q;
    logic [4*NUM_DIGITS-1:0] sh_dig_q, sh_dig_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic                    sh_lz_q, sh_lz_d;
    logic [3:0]              bcd_q, bcd_d;
    logic                    dp_q, dp_d;
    logic                    err_q, err_d;
    logic                    fs_q, fs_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [NUM_DIGITS-1:0]   supp;
    logic                    wrap, into0, capture;

    // Walk down from the top digit; suppression stops at the first non-zero digit or lit dp.
    always_comb begin
        logic run;
        int unsigned i;
        run  = sh_lz_q;
        supp = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            i       = NUM_DIGITS - 1 - k;
            run     = run && (sh_dig_q[4*i +: 4] == 4'd0) && !sh_dp_q[i];
            supp[i] = run && (i != 0);
        end
    end

    always_comb begin
        wrap    = (cnt_q == CW'(REFRESH_DIV - 1));
        into0   = wrap && (idx_q == IW'(NUM_DIGITS - 1));
        capture = into0 && (pending_q || load);

        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        sh_dig_d  = sh_dig_q;
        sh_dp_d   = sh_dp_q;
        sh_lz_d   = sh_lz_q;
        pending_d = pending_q | load;
        if (capture) begin
            sh_dig_d  = digits_in;
            sh_dp_d   = dp_in;
            sh_lz_d   = lz_en;
            pending_d = 1'b0;
        end

        state_d = state_q;
        case (state_q)
            BLANK:   if (cnt_d == CW'(BLANK_CYCLES)) state_d = SHOW;
            SHOW:    if (wrap) state_d = BLANK;
            default: state_d = BLANK;
        endcase

        an_d = '1;
        if (state_d == SHOW && !supp[idx_q]) begin
            an_d[idx_q] = 1'b0;
        end

        // Digit data moves on the wrap edge so it settles during the blanking guard.
        bcd_d = bcd_q;
        dp_d  = dp_q;
        err_d = err_q;
        if (wrap) begin
            bcd_d = sh_dig_d[4*idx_d +: 4];
            dp_d  = sh_dp_d[idx_d];
            err_d = (sh_dig_d[4*idx_d +: 4] > 4'd9);
        end

        fs_d = into0 || first_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BLANK;
            cnt_q     <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            first_q   <= 1'b1;
            sh_dig_q  <= '0;
            sh_dp_q   <= '0;
            sh_lz_q   <= 1'b0;
            bcd_q     <= '0;
            dp_q      <= 1'b0;
            err_q     <= 1'b0;
            fs_q      <= 1'b0;
            an_q      <= '1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            first_q   <= 1'b0;
            sh_dig_q  <= sh_dig_d;
            sh_dp_q   <= sh_dp_d;
            sh_lz_q   <= sh_lz_d;
            bcd_q     <= bcd_d;
            dp_q      <= dp_d;
            err_q     <= err_d;
            fs_q      <= fs_d;
            an_q      <= an_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign dp_out      = dp_q;
    assign an_out      = an_q;
    assign digit_err   = err_q;
    assign frame_start = fs_q;

endmodule
